// File: rtl/direction_key_conditioner.sv
// Four-button direction input stage: per-key 2-flop sync, debounce, up>down>left>right priority,
// registered one-hot/code outputs with a press strobe. Define AUTO_REPEAT_EN for hold auto-repeat.
module direction_key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned REPEAT_DELAY    = 100000000,
    parameter int unsigned REPEAT_PERIOD   = 20000000
) (
    input  logic       clk_200m,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    output logic [3:0] direction,
    output logic [1:0] dir_code,
    output logic       dir_pulse,
    output logic       key_valid
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HELD} state_t;
`endif

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_stable;
    logic [3:0] w_pressed;
    logic [3:0] w_win;
    logic [1:0] w_win_code;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_new_dir;
    logic       w_load;
    logic       w_release;
    logic       w_pulse;
    logic       w_rpt_fire;

    logic [3:0] r_direction;
    logic [1:0] r_dir_code;
    logic       r_dir_pulse;
    logic       r_key_valid;

    // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // A key's accepted level flips only after its synced level disagrees for DEBOUNCE_CYCLES edges.
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic             r_stable;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk_200m or negedge rst_n) begin
            if (!rst_n) begin
                r_stable <= 1'b1;
                r_cnt    <= '0;
            end else if (r_sync2[gi] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2[gi];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_stable[gi] = r_stable;
    end

    assign w_pressed = ~w_stable;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_win      = 4'b0000;
        w_win_code = 2'd0;
        if (w_pressed[3]) begin
            w_win      = 4'b1000;
            w_win_code = 2'd0;
        end else if (w_pressed[2]) begin
            w_win      = 4'b0100;
            w_win_code = 2'd1;
        end else if (w_pressed[1]) begin
            w_win      = 4'b0010;
            w_win_code = 2'd2;
        end else if (w_pressed[0]) begin
            w_win      = 4'b0001;
            w_win_code = 2'd3;
        end
    end

    // A new winner directly after a strobe waits one cycle so strobes never touch.
    assign w_new_dir = (w_win != 4'b0000) && (w_win != r_direction) && !r_dir_pulse;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned      RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                              : REPEAT_PERIOD;
    localparam int unsigned      RPT_W       = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] r_rpt_cnt;

    assign w_rpt_fire = (w_win != 4'b0000) && (w_win == r_direction) &&
                        (((r_state == S_HELD)   && (r_rpt_cnt == DELAY_LAST)) ||
                         ((r_state == S_REPEAT) && (r_rpt_cnt == PERIOD_LAST)));

    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt <= '0;
        end else if ((w_state_next == S_IDLE) || w_load || w_rpt_fire) begin
            r_rpt_cnt <= '0;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign w_rpt_fire = 1'b0;

    // Repeat intervals under two cycles could make strobes touch; this build never times them.
    if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2)) begin : g_repeat_cfg_out_of_range
    end
`endif

    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_new_dir) begin
                    w_state_next = S_HELD;
                end
            end
            S_HELD: begin
                if (w_win == 4'b0000) begin
                    w_state_next = S_IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if (w_rpt_fire) begin
                    w_state_next = S_REPEAT;
                end
`endif
            end
`ifdef AUTO_REPEAT_EN
            S_REPEAT: begin
                if (w_win == 4'b0000) begin
                    w_state_next = S_IDLE;
                end else if (w_new_dir) begin
                    w_state_next = S_HELD;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = w_new_dir;
            end
            default: begin
                w_load    = w_new_dir;
                w_release = (w_win == 4'b0000);
            end
        endcase
        w_pulse = w_load || w_rpt_fire;
    end

    // dir_code is left alone on release so it keeps the last direction shown.
    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            r_direction <= 4'b0000;
            r_dir_code  <= 2'd0;
            r_dir_pulse <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_dir_pulse <= w_pulse;
            if (w_load) begin
                r_direction <= w_win;
                r_dir_code  <= w_win_code;
                r_key_valid <= 1'b1;
            end else if (w_release) begin
                r_direction <= 4'b0000;
                r_key_valid <= 1'b0;
            end
        end
    end

    assign direction = r_direction;
    assign dir_code  = r_dir_code;
    assign dir_pulse = r_dir_pulse;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_direction_key_conditioner.sv
// Randomised and directed bench for direction_key_conditioner against a window-based reference model.
`timescale 1ns/1ps
module tb_direction_key_conditioner;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clk_200m = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] key_n    = 4'b1111;
    logic [3:0] direction;
    logic [1:0] dir_code;
    logic       dir_pulse;
    logic       key_valid;

    int n_checks = 0;
    int n_errors = 0;

    direction_key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_200m (clk_200m),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .direction(direction),
        .dir_code (dir_code),
        .dir_pulse(dir_pulse),
        .key_valid(key_valid)
    );

    always #5 clk_200m = ~clk_200m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a key's accepted level flips once its last D synced samples all disagree with it.
    logic [3:0] m_d1, m_d2, m_stable, m_win, m_dir;
    logic [1:0] m_code;
    logic       m_pulse, m_valid;
    int         m_since, m_repeats;
    logic [3:0] m_hist[$];

    function automatic logic [3:0] pick_winner(input logic [3:0] pressed);
        for (int i = 3; i >= 0; i--) if (pressed[i]) return 4'b0001 << i;
        return 4'b0000;
    endfunction

    function automatic logic [1:0] code_of(input logic [3:0] onehot);
        for (int i = 0; i < 4; i++) if (onehot[3-i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_d1 = 4'b1111; m_d2 = 4'b1111; m_stable = 4'b1111; m_win = 4'b0000;
        m_dir = 4'b0000; m_code = 2'd0; m_pulse = 1'b0; m_valid = 1'b0;
        m_since = 0; m_repeats = 0;
        m_hist.delete();
    endtask

    task automatic model_step();
        logic [3:0] s;
        logic       prev_pulse;
        bit         disagree;
        prev_pulse = m_pulse;
        m_pulse    = 1'b0;
        if (m_win == 4'b0000) begin
            m_dir = 4'b0000; m_valid = 1'b0; m_since = 0; m_repeats = 0;
        end else if (m_win != m_dir) begin
            if (!prev_pulse) begin
                m_dir = m_win; m_code = code_of(m_win); m_valid = 1'b1; m_pulse = 1'b1;
                m_since = 0; m_repeats = 0;
            end else begin
                m_since++;
            end
        end else begin
            m_since++;
`ifdef AUTO_REPEAT_EN
            if (m_since == ((m_repeats == 0) ? RD : RP)) begin
                m_pulse = 1'b1; m_since = 0; m_repeats++;
            end
`endif
        end
        s = m_d2; m_d2 = m_d1; m_d1 = key_n;
        m_hist.push_back(s);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        if (m_hist.size() == D) begin
            for (int k = 0; k < 4; k++) begin
                disagree = 1'b1;
                foreach (m_hist[j]) if (m_hist[j][k] == m_stable[k]) disagree = 1'b0;
                if (disagree) m_stable[k] = ~m_stable[k];
            end
        end
        m_win = pick_winner(~m_stable);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_200m or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    logic chk_en = 1'b0;
    logic prev_pulse_obs = 1'b0;

    initial begin
        forever begin
            @(negedge clk_200m);
            if (chk_en) begin
                check("direction", 32'(direction), 32'(m_dir));
                check("dir_code",  32'(dir_code),  32'(m_code));
                check("dir_pulse", 32'(dir_pulse), 32'(m_pulse));
                check("key_valid", 32'(key_valid), 32'(m_valid));
                check("pulse_gap", 32'(prev_pulse_obs & dir_pulse), 32'd0);
                prev_pulse_obs = dir_pulse;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // sel 0: wait for dir_pulse high; sel 1: wait for key_valid low. n = edges taken (max+1 on timeout).
    task automatic wait_for(input int sel, input int max_edges, output int n);
        n = max_edges + 1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk_200m); #1;
            if ((sel == 0 && dir_pulse) || (sel == 1 && !key_valid)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int edges, output int n);
        n = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk_200m); #1;
            if (dir_pulse) n++;
        end
    endtask

    initial begin
        int n;
        int exp_pulses;
        int hold;
        logic [3:0] pat;

        repeat (3) @(posedge clk_200m);
        #1;
        check("reset_direction", 32'(direction), 32'd0);
        check("reset_code",      32'(dir_code),  32'd0);
        check("reset_pulse",     32'(dir_pulse), 32'd0);
        check("reset_valid",     32'(key_valid), 32'd0);
        @(negedge clk_200m);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (4) @(negedge clk_200m);

        // Single up press
        key_n = 4'b0111;
        wait_for(0, 30, n);
        check("t1_latency",   32'(n),         32'd11);
        check("t1_direction", 32'(direction), 32'h8);
        check("t1_code",      32'(dir_code),  32'd0);
        check("t1_valid",     32'(key_valid), 32'd1);
        repeat (6) @(negedge clk_200m);

        // Release all from held
        key_n = 4'b1111;
        wait_for(1, 30, n);
        check("t4_latency",   32'(n),         32'd11);
        check("t4_direction", 32'(direction), 32'd0);
        check("t4_code_hold", 32'(dir_code),  32'd0);
        repeat (6) @(negedge clk_200m);

        // Short glitch on right
        key_n = 4'b1110;
        repeat (5) @(negedge clk_200m);
        key_n = 4'b1111;
        count_pulses(25, n);
        check("t2_pulses",    32'(n),         32'd0);
        check("t2_direction", 32'(direction), 32'd0);
        @(negedge clk_200m);

        // Up+right, then release up only
        key_n = 4'b0110;
        wait_for(0, 30, n);
        check("t3_latency_up", 32'(n),         32'd11);
        check("t3_dir_up",     32'(direction), 32'h8);
        repeat (5) @(negedge clk_200m);
        key_n = 4'b1110;
        wait_for(0, 30, n);
        check("t3_latency_right", 32'(n),         32'd11);
        check("t3_dir_right",     32'(direction), 32'h1);
        check("t3_code_right",    32'(dir_code),  32'd3);
        @(negedge clk_200m);
        key_n = 4'b1111;
        repeat (20) @(negedge clk_200m);
        check("t4_code_after_right", 32'(dir_code), 32'd3);

        // Long hold of left: count strobes over 71 edges after the press
        key_n = 4'b1101;
        count_pulses(71, n);
        exp_pulses = 1;
`ifdef AUTO_REPEAT_EN
        if (71 - 11 - RD >= 0) exp_pulses += (71 - 11 - RD) / RP + 1;
`endif
        check("t5_pulses",    32'(n),         32'(exp_pulses));
        check("t5_direction", 32'(direction), 32'h2);
        check("t5_code",      32'(dir_code),  32'd2);

        // Asynchronous reset mid-hold
        @(posedge clk_200m); #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_direction", 32'(direction), 32'd0);
        check("t6_async_valid",     32'(key_valid), 32'd0);
        check("t6_async_code",      32'(dir_code),  32'd0);
        check("t6_async_pulse",     32'(dir_pulse), 32'd0);
        repeat (2) @(negedge clk_200m);
        rst_n = 1'b1;
        prev_pulse_obs = 1'b0;
        wait_for(0, 30, n);
        check("t6_latency",   32'(n),         32'd11);
        check("t6_direction", 32'(direction), 32'h2);
        @(negedge clk_200m);
        key_n = 4'b1111;
        repeat (20) @(negedge clk_200m);

        // Random presses, glitches and holds
        for (int it = 0; it < 250; it++) begin
            pat  = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(1, 14);
            key_n = pat;
            repeat (hold) @(negedge clk_200m);
        end
        key_n = 4'b1111;
        repeat (25) @(negedge clk_200m);
        check("final_direction", 32'(direction), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
